// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product sequencer: MAC command opcodes
// and the sequencer state encoding.
package mac_pkg;

   localparam logic SETVAL = 1'b0;
   localparam logic MAC    = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      ACCEPT,
      GAP,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/mac_seq.sv
// Dot-product sequencer. It accepts operand pairs from an upstream stream
// and issues them as commands to an external two-cycle MAC datapath. The
// accumulator is cleared with SETVAL(0,0) at the start of every vector.
// Pairs are accepted at most every other cycle, so each MAC command sees
// the accumulator value written by the previous command. When the last
// command returns, its result is presented downstream with the pair count.
module mac_seq
   import mac_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [WIDTH-1:0]   s_a,
   input  logic [WIDTH-1:0]   s_b,
   input  logic               s_last,
   output logic               m_in_valid,
   output logic               m_in_action,
   output logic [WIDTH-1:0]   m_in_data_a,
   output logic [WIDTH-1:0]   m_in_data_b,
   input  logic               m_out_valid,
   input  logic [2*WIDTH-1:0] m_out_data,
   output logic               r_valid,
   input  logic               r_ready,
   output logic [2*WIDTH-1:0] r_data,
   output logic [CNT_W-1:0]   r_count
);

   state_t             state;
   state_t             state_nxt;
   logic               issue_nxt;
   logic               action_nxt;
   logic [WIDTH-1:0]   a_nxt;
   logic [WIDTH-1:0]   b_nxt;
   logic [1:0]         outstanding;
   logic               ret;
   logic               capture;
   logic               pair_hs;
   logic               result_hs;

   // Count up but stick at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      return v + CNT_W'(1);
   endfunction

   // Results only matter while a vector is in flight; stray returns while
   // idle or presenting a result are ignored.
   assign ret       = m_out_valid && (state != IDLE) && (state != DONE);
   // The last command is the only one outstanding when its result returns.
   assign capture   = (state == DRAIN) && ret && (outstanding == 2'd1);
   assign pair_hs   = (state == ACCEPT) && s_valid;
   assign result_hs = (state == DONE) && r_ready;

   // Next-state logic, handshake outputs and the command to register next.
   always_comb begin
      state_nxt  = state;
      s_ready    = 1'b0;
      r_valid    = 1'b0;
      issue_nxt  = 1'b0;
      action_nxt = SETVAL;
      a_nxt      = '0;
      b_nxt      = '0;
      case (state)
         IDLE: begin
            if (s_valid) begin
               issue_nxt = 1'b1;
               state_nxt = CLR;
            end
         end
         CLR: begin
            state_nxt = ACCEPT;
         end
         ACCEPT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               issue_nxt  = 1'b1;
               action_nxt = MAC;
               a_nxt      = s_a;
               b_nxt      = s_b;
               state_nxt  = s_last ? DRAIN : GAP;
            end
         end
         GAP: begin
            state_nxt = ACCEPT;
         end
         DRAIN: begin
            if (capture)
               state_nxt = DONE;
         end
         DONE: begin
            r_valid = 1'b1;
            if (r_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Command register: a one-cycle pulse per command, zeroed otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_in_valid  <= 1'b0;
         m_in_action <= SETVAL;
         m_in_data_a <= '0;
         m_in_data_b <= '0;
      end else begin
         m_in_valid  <= issue_nxt;
         m_in_action <= action_nxt;
         m_in_data_a <= a_nxt;
         m_in_data_b <= b_nxt;
      end
   end

   // Commands whose results have not yet returned, counted from the edge
   // that registers the command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= 2'd0;
      end else begin
         case ({issue_nxt, ret})
            2'b10: if (outstanding != 2'd3) outstanding <= outstanding + 2'd1;
            2'b01: if (outstanding != 2'd0) outstanding <= outstanding - 2'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Pair count for the current vector, cleared once the result is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (result_hs)
         r_count <= '0;
      else if (pair_hs)
         r_count <= sat_inc(r_count);
   end

   // Final accumulator value, held until the next vector completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_data <= '0;
      else if (capture)
         r_data <= m_out_data;
   end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a two-cycle MAC datapath model closes the loop, a
// vector table drives the main cases, and hand-written sequences cover
// result back-pressure and mid-vector reset.
module tb_mac_seq;
   import mac_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic               clk;
   logic               rst;
   logic               s_valid;
   logic               s_ready;
   logic [WIDTH-1:0]   s_a;
   logic [WIDTH-1:0]   s_b;
   logic               s_last;
   logic               m_in_valid;
   logic               m_in_action;
   logic [WIDTH-1:0]   m_in_data_a;
   logic [WIDTH-1:0]   m_in_data_b;
   logic               m_out_valid;
   logic [2*WIDTH-1:0] m_out_data;
   logic               r_valid;
   logic               r_ready;
   logic [2*WIDTH-1:0] r_data;
   logic [CNT_W-1:0]   r_count;

   mac_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
      .m_in_valid(m_in_valid), .m_in_action(m_in_action),
      .m_in_data_a(m_in_data_a), .m_in_data_b(m_in_data_b),
      .m_out_valid(m_out_valid), .m_out_data(m_out_data),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_count(r_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MAC datapath model: result valid two cycles after the command cycle.
   logic             dp_vld_p1;
   logic             dp_act_p1;
   logic [WIDTH-1:0] dp_a_p1;
   logic [WIDTH-1:0] dp_b_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_vld_p1   <= 1'b0;
         dp_act_p1   <= 1'b0;
         dp_a_p1     <= '0;
         dp_b_p1     <= '0;
         m_out_valid <= 1'b0;
         m_out_data  <= '0;
      end else begin
         dp_vld_p1   <= m_in_valid;
         dp_act_p1   <= m_in_action;
         dp_a_p1     <= m_in_data_a;
         dp_b_p1     <= m_in_data_b;
         m_out_valid <= dp_vld_p1;
         if (dp_vld_p1)
            m_out_data <= (dp_act_p1 ? m_out_data : 8'd0) +
                          ({4'd0, dp_a_p1} * {4'd0, dp_b_p1});
      end
   end

   typedef struct {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic               last;
      int                 idle;
      logic [2*WIDTH-1:0] exp_data;
      logic [CNT_W-1:0]   exp_count;
   } rec_t;

   typedef struct {
      logic [2*WIDTH-1:0] d;
      logic [CNT_W-1:0]   c;
   } exp_t;

   rec_t tbl[$];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input logic [3:0] a, input logic [3:0] b, input logic last,
                               input int idle, input logic [7:0] ed, input logic [7:0] ec);
      rec_t r;
      r.a = a; r.b = b; r.last = last; r.idle = idle; r.exp_data = ed; r.exp_count = ec;
      tbl.push_back(r);
   endfunction

   // Protocol monitor and scoreboard, sampled on the falling edge.
   logic prev_hs  = 1'b0;
   logic prev_miv = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (prev_hs)
         check("s_ready_after_handshake", s_ready, 0);
      if (m_in_valid && prev_miv)
         check("m_in_valid_single_cycle", 1, 0);
      if (!m_in_valid)
         check("idle_command_zero", {m_in_action, m_in_data_a, m_in_data_b}, 0);
      if (r_valid && r_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("r_data", r_data, e.d);
            check("r_count", r_count, e.c);
         end
      end
      prev_hs  = s_valid && s_ready;
      prev_miv = m_in_valid;
   end

   // Offer one pair and return just after the edge that accepts it.
   task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
      bit found = 0;
      s_a = a; s_b = b; s_last = last; s_valid = 1'b1;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (s_ready) found = 1;
      end
      if (!found) check("s_ready_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   // Count falling edges until r_valid is seen.
   task automatic wait_result(output int lat);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (r_valid) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) check("result_timeout", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_s_ready"},     s_ready, 0);
      check({tag, "_m_in_valid"},  m_in_valid, 0);
      check({tag, "_m_in_action"}, m_in_action, 0);
      check({tag, "_m_in_a"},      m_in_data_a, 0);
      check({tag, "_m_in_b"},      m_in_data_b, 0);
      check({tag, "_r_valid"},     r_valid, 0);
      check({tag, "_r_data"},      r_data, 0);
      check({tag, "_r_count"},     r_count, 0);
   endtask

   initial begin
      int   lat;
      rec_t r;
      logic [7:0] sum;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      rec_t r;
      logic [7:0] sum;
      rst = 1'b1; s_valid = 0; s_a = 0; s_b = 0; s_last = 0; r_ready = 1'b1;

      // Vector table: expectations on each vector's last pair.
      add(3, 5, 1, 0, 8'd15, 8'd1);
      add(2, 3, 0, 0, 0, 0);
      add(4, 5, 0, 0, 0, 0);
      add(1, 7, 1, 0, 8'd33, 8'd3);
      for (int i = 0; i < 18; i++)
         add(15, 15, i == 17, 0, 8'd210, 8'd18);
      add(1, 2, 0, 0, 0, 0);
      add(3, 4, 1, 10, 8'd14, 8'd2);
      sum = 0;
      for (int i = 0; i < 257; i++) begin
         sum = sum + 8'd1;
         add(1, 1, i == 256, 0, sum, 8'd255);
      end

      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (tbl[k]) begin
         r = tbl[k];
         if (r.idle > 0) begin
            s_valid = 1'b0;
            for (int i = 0; i < r.idle; i++) begin
               @(negedge clk);
               if (i > 0) check("gap_m_in_valid", m_in_valid, 0);
               @(posedge clk); #1;
            end
         end
         if (r.last) exp_q.push_back('{r.exp_data, r.exp_count});
         send_pair(r.a, r.b, r.last);
         if (r.last) begin
            s_valid = 1'b0; s_last = 1'b0;
            wait_result(lat);
            check("latency_edges", lat - 1, 3);
            @(posedge clk); #1;
         end
      end

      // Result held under back-pressure while the next vector waits.
      r_ready = 1'b0;
      exp_q.push_back('{8'd36, 8'd1});
      send_pair(6, 6, 1);
      s_valid = 1'b0;
      wait_result(lat);
      for (int i = 0; i < 5; i++) begin
         check("hold_r_valid", r_valid, 1);
         check("hold_r_data", r_data, 36);
         check("hold_r_count", r_count, 1);
         check("hold_s_ready", s_ready, 0);
         @(posedge clk); #1;
         if (i == 0) begin
            s_a = 1; s_b = 1; s_last = 1; s_valid = 1'b1;
         end
         if (i < 4) @(negedge clk);
      end
      r_ready = 1'b1;
      exp_q.push_back('{8'd1, 8'd1});
      send_pair(1, 1, 1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_result(lat);
      check("latency_after_hold", lat - 1, 3);
      @(posedge clk); #1;

      // Reset in the middle of a vector abandons it.
      send_pair(1, 1, 0);
      send_pair(2, 2, 0);
      s_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back('{8'd4, 8'd1});
      send_pair(2, 2, 1);
      s_valid = 1'b0; s_last = 1'b0;
      wait_result(lat);
      check("latency_after_reset", lat - 1, 3);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      check("results_outstanding", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
